// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I(+M) multi-cycle control unit:
// opcodes, ALU codes, mux-select encodings and FSM states.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;
    localparam logic [1:0] WD_MD  = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_MD_WAIT,
        S_WB,
        S_TRAP
    } state_e;

    function automatic logic opc_known(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_BRANCH, OPC_LOAD, OPC_STORE,
            OPC_OPIMM, OPC_OP: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_arith(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [3:0] r;
        case (f3)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of the latched instruction fields into
// datapath mux selects, ALU op and instruction-class flags.
module ctrl_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_i,
    input  logic       funct7_m_i,
    output logic [3:0] alu_ctrl_o,
    output logic       a_sel_o,
    output logic       b_sel_o,
    output logic [1:0] wd_src_o,
    output logic [2:0] imm_sel_o,
    output logic       mask_o,
    output logic       dm_sel_o,
    output logic       st_sel_o,
    output logic       is_load_o,
    output logic       is_store_o,
    output logic       is_branch_o,
    output logic       is_jump_o,
    output logic       is_md_o
);

    logic is_op, is_alu_r, is_opimm;
    logic is_lui, is_auipc, is_jal, is_jalr, is_mem;

    assign is_op       = opcode_i == OPC_OP;
    assign is_opimm    = opcode_i == OPC_OPIMM;
    assign is_lui      = opcode_i == OPC_LUI;
    assign is_auipc    = opcode_i == OPC_AUIPC;
    assign is_jal      = opcode_i == OPC_JAL;
    assign is_jalr     = opcode_i == OPC_JALR;
    assign is_load_o   = opcode_i == OPC_LOAD;
    assign is_store_o  = opcode_i == OPC_STORE;
    assign is_branch_o = opcode_i == OPC_BRANCH;
    assign is_jump_o   = is_jal | is_jalr;
    assign is_md_o     = is_op & funct7_m_i;
    assign is_alu_r    = is_op & ~funct7_m_i;
    assign is_mem      = is_load_o | is_store_o;

    assign mask_o   = is_mem & ~funct3_i[1];
    assign dm_sel_o = is_mem & funct3_i[0];
    assign st_sel_o = is_load_o & funct3_i[2];

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        a_sel_o    = 1'b0;
        b_sel_o    = 1'b0;
        wd_src_o   = WD_ALU;
        imm_sel_o  = IMM_I;
        unique case (1'b1)
            is_md_o:  wd_src_o = WD_MD;
            is_alu_r: alu_ctrl_o = alu_arith(funct3_i, funct7_i);
            is_opimm: begin
                // only SRAI uses instr[30]; elsewhere it is immediate bits
                alu_ctrl_o = alu_arith(funct3_i,
                                       funct7_i & (funct3_i == 3'b101));
                b_sel_o    = 1'b1;
            end
            is_load_o: begin
                b_sel_o  = 1'b1;
                wd_src_o = WD_MEM;
            end
            is_store_o: begin
                b_sel_o   = 1'b1;
                imm_sel_o = IMM_S;
            end
            is_branch_o: begin
                imm_sel_o  = IMM_B;
                alu_ctrl_o = !funct3_i[2] ? ALU_SUB :
                             !funct3_i[1] ? ALU_SLT : ALU_SLTU;
            end
            is_lui: begin
                alu_ctrl_o = ALU_PASSB;
                b_sel_o    = 1'b1;
                imm_sel_o  = IMM_U;
            end
            is_auipc: begin
                a_sel_o   = 1'b1;
                b_sel_o   = 1'b1;
                imm_sel_o = IMM_U;
            end
            is_jal: begin
                a_sel_o   = 1'b1;
                b_sel_o   = 1'b1;
                wd_src_o  = WD_PC4;
                imm_sel_o = IMM_J;
            end
            is_jalr: begin
                b_sel_o  = 1'b1;
                wd_src_o = WD_PC4;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I(+M) control FSM: FETCH/DECODE/EXEC/MEM/WB
// sequencing with memory and mul/div wait handshakes.
module multicycle_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int EN_MULDIV  = 0,
    parameter int MD_LATENCY = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7,
    input  logic                  funct7_m,
    input  logic                  instr_valid,
    input  logic                  dm_ready,
    input  logic                  branch_taken,
    output logic [ALU_CTRL_W-1:0] ALU_Ctrl,
    output logic                  A_select,
    output logic                  B_select,
    output logic [1:0]            wd_src,
    output logic                  Mask,
    output logic                  dm_select,
    output logic                  store_select,
    output logic [2:0]            imm_select,
    output logic                  PC_src,
    output logic                  dm_read,
    output logic                  dm_write,
    output logic                  reg_write,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  md_start,
    output logic                  illegal
);

    localparam logic [7:0] MD_INIT = 8'(MD_LATENCY - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [6:0] op_q;
    logic [2:0] f3_q;
    logic       f7_q, f7m_q;

    logic [3:0] alu;
    logic [1:0] wd;
    logic [2:0] imm;
    logic       a_sel, b_sel, mask, dm_sel, st_sel;
    logic       is_ld, is_st, is_br, is_jmp, is_md;
    logic       legal;
    logic       ir_w, dm_rd, dm_wr, reg_w, pc_w, pc_s, md_s;

    ctrl_decode u_dec (
        .opcode_i    (op_q),
        .funct3_i    (f3_q),
        .funct7_i    (f7_q),
        .funct7_m_i  (f7m_q),
        .alu_ctrl_o  (alu),
        .a_sel_o     (a_sel),
        .b_sel_o     (b_sel),
        .wd_src_o    (wd),
        .imm_sel_o   (imm),
        .mask_o      (mask),
        .dm_sel_o    (dm_sel),
        .st_sel_o    (st_sel),
        .is_load_o   (is_ld),
        .is_store_o  (is_st),
        .is_branch_o (is_br),
        .is_jump_o   (is_jmp),
        .is_md_o     (is_md)
    );

    assign legal = opc_known(opcode) &&
                   !(opcode == OPC_OP && funct7_m && EN_MULDIV == 0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            op_q    <= '0;
            f3_q    <= '0;
            f7_q    <= 1'b0;
            f7m_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_DECODE) begin
                op_q  <= opcode;
                f3_q  <= funct3;
                f7_q  <= funct7;
                f7m_q <= funct7_m;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ir_w    = 1'b0;
        dm_rd   = 1'b0;
        dm_wr   = 1'b0;
        reg_w   = 1'b0;
        pc_w    = 1'b0;
        pc_s    = 1'b0;
        md_s    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                ir_w = instr_valid;
                if (instr_valid) state_d = S_DECODE;
            end
            S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                unique case (1'b1)
                    is_ld, is_st: state_d = S_MEM;
                    is_br: begin
                        pc_w    = 1'b1;
                        pc_s    = branch_taken;
                        state_d = S_FETCH;
                    end
                    is_jmp: begin
                        pc_w    = 1'b1;
                        pc_s    = 1'b1;
                        state_d = S_WB;
                    end
                    is_md: begin
                        md_s    = 1'b1;
                        cnt_d   = MD_INIT;
                        state_d = S_MD_WAIT;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dm_rd = is_ld;
                dm_wr = is_st;
                if (dm_ready) begin
                    pc_w    = is_st;
                    state_d = is_st ? S_FETCH : S_WB;
                end
            end
            S_MD_WAIT: begin
                if (cnt_q == '0) state_d = S_WB;
                else             cnt_d   = cnt_q - 8'd1;
            end
            S_WB: begin
                // jumps already redirected the PC in EXEC
                reg_w   = 1'b1;
                pc_w    = !is_jmp;
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    assign ALU_Ctrl     = reset ? '0 : ALU_CTRL_W'(alu);
    assign A_select     = a_sel & ~reset;
    assign B_select     = b_sel & ~reset;
    assign wd_src       = reset ? WD_ALU : wd;
    assign Mask         = mask & ~reset;
    assign dm_select    = dm_sel & ~reset;
    assign store_select = st_sel & ~reset;
    assign imm_select   = reset ? IMM_I : imm;
    assign PC_src       = pc_s & ~reset;
    assign dm_read      = dm_rd & ~reset;
    assign dm_write     = dm_wr & ~reset;
    assign reg_write    = reg_w & ~reset;
    assign pc_write     = pc_w & ~reset;
    assign ir_write     = ir_w & ~reset;
    assign md_start     = md_s & ~reset;
    assign illegal      = (state_q == S_TRAP) & ~reset;

endmodule
